// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed scan driver that feeds a hex-to-7-segment decoder.
//   It holds a DIGITS-wide hex word and one decimal point per digit, and
//   presents one digit at a time on hex_out/dp_out. The anode selects are
//   active low. Each digit slot starts with BLANK_CYC cycles of all-dark
//   anodes to stop ghosting. Leading zeros can be blanked. A new value is
//   taken from a pending buffer only at a frame boundary, so a frame never
//   mixes old and new digits.
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   value_in     hex word; digit k = value_in[4k+3:4k], digit 0 = rightmost
//   dp_in        decimal point per digit, 1 = lit
//   load_req     1-cycle strobe that captures value_in/dp_in into pending
//   blank_lz     1 = suppress leading zero digits (sampled live)
//   load_ack     1-cycle pulse when the captured data becomes visible
//   hex_out      nibble of the active digit
//   dp_out       decimal point of the active digit
//   an_n         anode selects, active low, at most one low
//   frame_tick   1-cycle pulse at each frame boundary

// Leading-zero decision for one digit position. A digit is blanked only
// when it is zero, has no decimal point, and every digit above it is
// blanked too. The top digit gets upper_blank tied high. Digit 0 is never
// blanked.
module seg_scan_digit #(
    parameter bit LSD = 1'b0
) (
    input  logic       blank_lz,
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       upper_blank,
    output logic       blank
);
    assign blank = !LSD && blank_lz && (nib == 4'h0) && !dp && upper_blank;
endmodule

module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load_req,
    input  logic                  blank_lz,
    output logic                  load_ack,
    output logic [3:0]            hex_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_tick
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_P    = PW'(BLANK_CYC);
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

    typedef struct packed {
        logic [DIGITS-1:0][3:0] val;
        logic [DIGITS-1:0]      dp;
    } frame_t;

    logic [PW-1:0]     presc;
    logic [DW-1:0]     dig;
    frame_t            disp, pend;
    logic              pend_valid;
    logic              slot_end, frame_end;
    logic [DIGITS-1:0] blanked, upper;
    logic [DIGITS-1:0] an_nxt;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (dig == DIG_LAST);

    // Blanking chain, from the top digit down.
    for (genvar g = 0; g < DIGITS; g++) begin : g_lane
        if (g == DIGITS - 1) begin : g_top
            assign upper[g] = 1'b1;
        end else begin : g_mid
            assign upper[g] = blanked[g+1];
        end
        seg_scan_digit #(.LSD(g == 0)) u_dig (
            .blank_lz    (blank_lz),
            .nib         (disp.val[g]),
            .dp          (disp.dp[g]),
            .upper_blank (upper[g]),
            .blank       (blanked[g])
        );
    end

    always_comb begin
        an_nxt = '1;
        if (presc >= BLANK_P && !blanked[dig])
            an_nxt[dig] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            dig        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            load_ack   <= 1'b0;
            hex_out    <= 4'h0;
            dp_out     <= 1'b0;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end)
                dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;

            // If a load arrives on the same edge as a commit, the old pending
            // data goes to the display and the new data waits for the next frame.
            if (load_req) begin
                pend.val   <= value_in;
                pend.dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
            if (frame_end && pend_valid)
                disp <= pend;
            load_ack <= frame_end && pend_valid;

            hex_out    <= disp.val[dig];
            dp_out     <= disp.dp[dig];
            an_n       <= an_nxt;
            frame_tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, REFRESH_DIV=8,
// BLANK_CYC=2. Outputs are sampled on the falling edge. A "frame capture"
// runs from the cycle after a frame_tick up to and including the next
// frame_tick, so it sees every slot of exactly one displayed frame. The
// load_ack pulse that commits the following frame lands on the last sample.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load_req = 1'b0;
    logic        blank_lz = 1'b0;
    logic        load_ack;
    logic [3:0]  hex_out;
    logic        dp_out;
    logic [3:0]  an_n;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
        .load_req(load_req), .blank_lz(blank_lz), .load_ack(load_ack),
        .hex_out(hex_out), .dp_out(dp_out), .an_n(an_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Captures one frame. Up to two load requests can be fired at sample
    // indices ra/rb; 0 means no request.
    task automatic capture(input int ra, input logic [15:0] va, input logic [3:0] da,
                           input int rb, input logic [15:0] vb, input logic [3:0] db,
                           output logic [15:0] v, output logic [3:0] d,
                           output logic [3:0] lit, output int acks, output logic ft);
        v = '0; d = '0; lit = '0; acks = 0; ft = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (load_ack) acks++;
            for (int j = 0; j < 4; j++)
                if (!an_n[j]) begin
                    lit[j] = 1'b1;
                    v[4*j +: 4] = hex_out;
                    d[j] = dp_out;
                end
            if (k == 32) ft = frame_tick;
            load_req = (k == ra) || (k == rb);
            if (k == ra) begin value_in = va; dp_in = da; end
            if (k == rb) begin value_in = vb; dp_in = db; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (an_n !== 4'b1111) begin miscompares++; $display("FAIL rst_an_n got %b want 1111", an_n); end
        vectors++; if (hex_out !== 4'h0) begin miscompares++; $display("FAIL rst_hex got %h want 0", hex_out); end
        vectors++; if (dp_out !== 1'b0) begin miscompares++; $display("FAIL rst_dp got %b want 0", dp_out); end
        vectors++; if (load_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack got %b want 0", load_ack); end
        vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL rst_tick got %b want 0", frame_tick); end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vectors++;
            if (an_n !== ((k >= 3) ? 4'b1110 : 4'b1111)) begin
                miscompares++; $display("FAIL slot_an_n cyc %0d got %b want %b", k, an_n, (k >= 3) ? 4'b1110 : 4'b1111);
            end
            if (k >= 3) begin
                vectors++; if (hex_out !== 4'h0) begin miscompares++; $display("FAIL slot_hex cyc %0d got %h want 0", k, hex_out); end
            end
        end
    endtask

    task automatic sync_frame;
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 200);
        vectors++;
        if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL sync_timeout got no frame_tick want frame_tick=1"); end
    endtask

    task automatic test_load;
        logic [15:0] v; logic [3:0] d, lit; int acks; logic ft;
        capture(5, 16'h3A7F, 4'b0010, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h0000 || lit !== 4'b1111) begin miscompares++; $display("FAIL load_f1 got %h/%b want 0000/1111", v, lit); end
        vectors++; if (acks !== 1 || ft !== 1'b1) begin miscompares++; $display("FAIL load_ack1 got %0d/%b want 1/1", acks, ft); end
        capture(0, '0, '0, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h3A7F) begin miscompares++; $display("FAIL load_val got %h want 3a7f", v); end
        vectors++; if (d !== 4'b0010) begin miscompares++; $display("FAIL load_dp got %b want 0010", d); end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL load_ack2 got %0d want 0", acks); end
    endtask

    task automatic test_latest_wins;
        logic [15:0] v; logic [3:0] d, lit; int acks; logic ft;
        capture(3, 16'h1111, 4'b0000, 20, 16'h2222, 4'b0000, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h3A7F) begin miscompares++; $display("FAIL lw_f1 got %h want 3a7f", v); end
        vectors++; if (acks !== 1) begin miscompares++; $display("FAIL lw_ack got %0d want 1", acks); end
        capture(0, '0, '0, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h2222 || d !== 4'b0000) begin miscompares++; $display("FAIL lw_val got %h/%b want 2222/0000", v, d); end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL lw_ack2 got %0d want 0", acks); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v; logic [3:0] d, lit; int acks; logic ft;
        // Second request lands on the frame_end edge itself.
        capture(10, 16'h00FF, 4'b0000, 31, 16'h0001, 4'b0000, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h2222 || acks !== 1) begin miscompares++; $display("FAIL b2b_f1 got %h/%0d want 2222/1", v, acks); end
        capture(0, '0, '0, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h00FF || acks !== 1) begin miscompares++; $display("FAIL b2b_f2 got %h/%0d want 00ff/1", v, acks); end
        capture(0, '0, '0, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (v !== 16'h0001 || acks !== 0) begin miscompares++; $display("FAIL b2b_f3 got %h/%0d want 0001/0", v, acks); end
    endtask

    task automatic test_lz;
        logic [15:0] v; logic [3:0] d, lit; int acks; logic ft;
        blank_lz = 1'b1;
        capture(5, 16'h0050, 4'b0000, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (lit !== 4'b0001 || v !== 16'h0001) begin miscompares++; $display("FAIL lz_0001 got %b/%h want 0001/0001", lit, v); end
        capture(5, 16'h0000, 4'b0000, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (lit !== 4'b0011 || v !== 16'h0050) begin miscompares++; $display("FAIL lz_0050 got %b/%h want 0011/0050", lit, v); end
        capture(5, 16'h5678, 4'b0000, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (lit !== 4'b0001 || v !== 16'h0000) begin miscompares++; $display("FAIL lz_0000 got %b/%h want 0001/0000", lit, v); end
        vectors++; if (acks !== 1) begin miscompares++; $display("FAIL lz_ack got %0d want 1", acks); end
        blank_lz = 1'b0;
        capture(0, '0, '0, 0, '0, '0, v, d, lit, acks, ft);
        vectors++; if (lit !== 4'b1111 || v !== 16'h5678) begin miscompares++; $display("FAIL lz_off got %b/%h want 1111/5678", lit, v); end
    endtask

    task automatic test_reset_mid;
        int acks, ticks, bad;
        logic [3:0] lit;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            load_req = (k == 2);
            if (k == 2) value_in = 16'h1234;
        end
        rst_n = 1'b0;
        #1;
        vectors++; if (an_n !== 4'b1111 || hex_out !== 4'h0 || dp_out !== 1'b0) begin
            miscompares++; $display("FAIL midrst_out got %b/%h/%b want 1111/0/0", an_n, hex_out, dp_out);
        end
        vectors++; if (load_ack !== 1'b0 || frame_tick !== 1'b0) begin
            miscompares++; $display("FAIL midrst_pulse got %b/%b want 0/0", load_ack, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0; ticks = 0; bad = 0; lit = '0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (load_ack) acks++;
            if (frame_tick) ticks++;
            for (int j = 0; j < 4; j++)
                if (!an_n[j]) begin
                    lit[j] = 1'b1;
                    if (hex_out !== 4'h0) bad++;
                end
        end
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL midrst_ack got %0d want 0", acks); end
        vectors++; if (bad !== 0 || lit !== 4'b1111) begin miscompares++; $display("FAIL midrst_disp got bad=%0d lit=%b want 0/1111", bad, lit); end
        vectors++; if (ticks !== 2) begin miscompares++; $display("FAIL midrst_ticks got %0d want 2", ticks); end
    endtask

    initial begin
        test_reset;
        sync_frame;
        test_load;
        test_latest_wins;
        test_back_to_back;
        test_lz;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
